// File: rtl/mesh_pkg.sv
// Shared definitions for the mesh readout path: default sizes, FSM encoding
// and the expected descending-sort value used by the optional result checker.
package mesh_pkg;

   localparam int N_DEF             = 4;
   localparam int DATA_WIDTH_DEF    = 32;
   localparam int ADDR_WIDTH_DEF    = 2;
   localparam int SETTLE_CYCLES_DEF = 4;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETTLE = 3'd1,
      SNAP   = 3'd2,
      STREAM = 3'd3,
      DONE   = 3'd4
   } state_e;

   // After a descending sort, PE k holds the value N-1-k.
   function automatic int unsigned expected_word(input int unsigned n, input int unsigned k);
      return n - 1 - k;
   endfunction

endpackage

// File: rtl/mesh_readout_snapshot.sv
// N x DATA_WIDTH shadow bank: captures every PE word at once on a strobe and
// serves one word through an indexed read mux.
module mesh_readout_snapshot
   import mesh_pkg::*;
#(
   parameter int N          = N_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    capture,
   input  logic [N*DATA_WIDTH-1:0] pe_mem,
   input  logic [ADDR_WIDTH-1:0]   rd_idx,
   output logic [DATA_WIDTH-1:0]   rd_data
);

   logic [N*DATA_WIDTH-1:0] shadow_d, shadow_q;

   always_comb begin
      shadow_d = shadow_q;
      if (capture) shadow_d = pe_mem;
   end

   always_ff @(posedge clk) begin
      if (!rst) shadow_q <= '0;
      else      shadow_q <= shadow_d;
   end

   // Indices at or beyond N read as zero.
   always_comb begin
      rd_data = '0;
      for (int k = 0; k < N; k++) begin
         if (rd_idx == ADDR_WIDTH'(k)) rd_data = shadow_q[k*DATA_WIDTH +: DATA_WIDTH];
      end
   end

endmodule

// File: rtl/mesh_readout.sv
// Mesh readout: waits for the sort to settle, snapshots all PE words and streams
// them in PE order over valid/ready. MESH_READOUT_CHECK_EN adds err/err_count.
module mesh_readout
   import mesh_pkg::*;
#(
   parameter int N             = N_DEF,
   parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH    = ADDR_WIDTH_DEF,
   parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [N*DATA_WIDTH-1:0] pe_mem,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [ADDR_WIDTH-1:0]   out_addr,
   output logic [DATA_WIDTH-1:0]   out_data,
   output logic                    out_last,
   output logic                    busy,
   output logic                    done
`ifdef MESH_READOUT_CHECK_EN
   ,
   output logic                    err,
   output logic [ADDR_WIDTH:0]     err_count
`endif
);

   localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   state_e                  state_d, state_q;
   logic [CW-1:0]           cnt_d, cnt_q;
   logic [ADDR_WIDTH-1:0]   idx_d, idx_q;
   logic                    out_valid_d, out_valid_q;
   logic [ADDR_WIDTH-1:0]   out_addr_d, out_addr_q;
   logic [DATA_WIDTH-1:0]   out_data_d, out_data_q;
   logic                    out_last_d, out_last_q;
   logic                    busy_d, busy_q;
   logic                    done_d, done_q;

   logic                    capture;
   logic                    hs;
   logic [ADDR_WIDTH-1:0]   idx_nxt;
   logic [DATA_WIDTH-1:0]   snap_rd_data;

   assign hs      = out_valid_q & out_ready;
   assign idx_nxt = idx_q + 1'b1;

   // The mux always looks one word ahead so the next word registers on accept.
   mesh_readout_snapshot #(
      .N          (N),
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_snapshot (
      .clk     (clk),
      .rst     (rst),
      .capture (capture),
      .pe_mem  (pe_mem),
      .rd_idx  (idx_nxt),
      .rd_data (snap_rd_data)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      out_valid_d = out_valid_q;
      out_addr_d  = out_addr_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      done_d      = 1'b0;
      capture     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               cnt_d   = '0;
               state_d = (SETTLE_CYCLES == 0) ? SNAP : SETTLE;
            end
         end
         SETTLE: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(SETTLE_CYCLES - 1)) state_d = SNAP;
         end
         SNAP: begin
            // Word 0 bypasses the bank: it is being captured on this same edge.
            capture     = 1'b1;
            idx_d       = '0;
            out_valid_d = 1'b1;
            out_addr_d  = '0;
            out_data_d  = pe_mem[DATA_WIDTH-1:0];
            out_last_d  = (N == 1);
            state_d     = STREAM;
         end
         STREAM: begin
            if (hs) begin
               if (out_last_q) begin
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  done_d      = 1'b1;
                  state_d     = DONE;
               end else begin
                  idx_d      = idx_nxt;
                  out_addr_d = idx_nxt;
                  out_data_d = snap_rd_data;
                  out_last_d = (idx_nxt == ADDR_WIDTH'(N - 1));
               end
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         out_valid_q <= 1'b0;
         out_addr_q  <= '0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         out_valid_q <= out_valid_d;
         out_addr_q  <= out_addr_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_addr  = out_addr_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign busy      = busy_q;
   assign done      = done_q;

`ifdef MESH_READOUT_CHECK_EN
   logic                  err_d, err_q;
   logic [ADDR_WIDTH:0]   err_count_d, err_count_q;
   logic [DATA_WIDTH-1:0] exp_word;

   assign exp_word = DATA_WIDTH'(expected_word(N, 32'(out_addr_q)));

   always_comb begin
      err_d       = err_q;
      err_count_d = err_count_q;
      if (state_q == IDLE && start) begin
         err_d       = 1'b0;
         err_count_d = '0;
      end else if (hs && (out_data_q != exp_word)) begin
         err_d = 1'b1;
         if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         err_q       <= 1'b0;
         err_count_q <= '0;
      end else begin
         err_q       <= err_d;
         err_count_q <= err_count_d;
      end
   end

   assign err       = err_q;
   assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_mesh_readout.sv
// Scoreboard bench for mesh_readout: stimulus pushes expected words, a negedge
// monitor pops and compares on every handshake. Honors MESH_READOUT_CHECK_EN.
module tb_mesh_readout;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int AW = 2;
   localparam int SC = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [N*DW-1:0] pe_mem = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [AW-1:0] out_addr;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          busy;
   logic          done;
`ifdef MESH_READOUT_CHECK_EN
   logic          err;
   logic [AW:0]   err_count;
`endif

   always #5 clk = ~clk;

   mesh_readout #(.N(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SETTLE_CYCLES(SC)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .pe_mem    (pe_mem),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_addr  (out_addr),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done)
`ifdef MESH_READOUT_CHECK_EN
      ,
      .err       (err),
      .err_count (err_count)
`endif
   );

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          last;
   } word_t;

   word_t exp_q[$];
   int    tests = 0;
   int    fails = 0;
   int    mism = 0;
   bit    expect_done = 1'b0;
   bit    held = 1'b0;
   word_t held_w;
   int    ready_mode = 0;
   int    rcyc = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Ready pattern: 0 = always high, 1 = 1,0,0 repeating, other = random.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         rcyc++;
         case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (rcyc % 3 == 0);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   always @(negedge clk) begin
      word_t cur;
      word_t e;
      if (rst) begin
         cur = {out_addr, out_data, out_last};
         chk("done_pulse", 64'(done), 64'(expect_done));
         expect_done = 1'b0;
         if (held) chk("hold_stable", 64'({out_valid, cur}), 64'({1'b1, held_w}));
         held = 1'b0;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_word", 64'(cur), 64'(0));
            end else begin
               e = exp_q.pop_front();
               chk("word", 64'(cur), 64'(e));
            end
            if (out_data != DW'(N - 1 - int'(out_addr))) mism++;
            if (out_last) expect_done = 1'b1;
         end else if (out_valid) begin
            held   = 1'b1;
            held_w = cur;
         end
      end else begin
         expect_done = 1'b0;
         held        = 1'b0;
      end
   end

   task automatic push_expected(input logic [N*DW-1:0] mem);
      word_t w;
      for (int k = 0; k < N; k++) begin
         w.addr = AW'(k);
         w.data = mem[k*DW +: DW];
         w.last = (k == N - 1);
         exp_q.push_back(w);
      end
   endtask

   task automatic pulse_start_and_time();
      int lat;
      start = 1'b1;
      mism  = 0;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 50);
      chk("latency", 64'(lat), 64'(SC + 2));
   endtask

   task automatic run_readout(input logic [N*DW-1:0] mem, input int mode,
                              input bit scramble, input bit hold_start);
      int guard;
      ready_mode = mode;
      pe_mem     = mem;
      push_expected(mem);
      pulse_start_and_time();
      if (scramble) begin
         @(posedge clk);
         #1 pe_mem = '1;
      end
      if (hold_start) begin
         @(posedge clk);
         #1 start = 1'b1;
         repeat (3) @(posedge clk);
         #1 start = 1'b0;
      end
      guard = 0;
      while (!done && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      chk("done_seen", 64'(done), 64'(1));
      chk("queue_drained", 64'(exp_q.size()), 64'(0));
`ifdef MESH_READOUT_CHECK_EN
      chk("err", 64'(err), 64'(mism != 0));
      chk("err_count", 64'(err_count), 64'(mism));
`endif
      exp_q.delete();
      @(negedge clk);
      chk("idle_after_done", 64'({busy, out_valid}), 64'(0));
   endtask

   task automatic abort_test(input logic [N*DW-1:0] mem);
      int guard;
      ready_mode = 0;
      pe_mem     = mem;
      push_expected(mem);
      pulse_start_and_time();
      guard = 0;
      while (!(out_valid && out_addr == AW'(1)) && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      chk("abort_reach_word1", 64'({out_valid, out_addr}), 64'({1'b1, AW'(1)}));
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      chk("abort_outputs", 64'({out_valid, out_addr, out_data, out_last, busy, done}), 64'(0));
      repeat (6) @(negedge clk);
      chk("abort_stays_idle", 64'(busy), 64'(0));
   endtask

   logic [N*DW-1:0] mem_nom, mem_bad, mem_rnd;

   initial begin
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", 64'(out_valid), 64'(0));
      chk("rst_addr",  64'(out_addr),  64'(0));
      chk("rst_data",  64'(out_data),  64'(0));
      chk("rst_last",  64'(out_last),  64'(0));
      chk("rst_busy",  64'(busy),      64'(0));
      chk("rst_done",  64'(done),      64'(0));

      mem_nom = {32'd0, 32'd1, 32'd2, 32'd3};
      mem_bad = {32'd0, 32'd7, 32'd2, 32'd3};
      run_readout(mem_nom, 0, 1'b0, 1'b0);
      run_readout(mem_nom, 1, 1'b0, 1'b0);
      run_readout(mem_nom, 0, 1'b1, 1'b0);
      run_readout(mem_bad, 0, 1'b0, 1'b0);
      run_readout(mem_nom, 0, 1'b0, 1'b0);
      run_readout(mem_nom, 1, 1'b0, 1'b1);
      abort_test(mem_nom);
      run_readout(mem_nom, 0, 1'b0, 1'b0);

      repeat (10) begin
         for (int k = 0; k < N; k++) begin
            mem_rnd[k*DW +: DW] = ($urandom_range(0, 1) == 1) ? DW'(N - 1 - k) : DW'($urandom);
         end
         run_readout(mem_rnd, 2, 1'($urandom_range(0, 1)), 1'b0);
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
